// File: rtl/scratchpad_port_arbiter_if.sv
// Minimal TL-UL request/response types, and an interface that bundles the host
// and device sides of the scratchpad port arbiter.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

interface scratchpad_port_arbiter_if #(
  parameter int NumHosts = 2
);
  tlul_pkg::tl_h2d_t tl_h_req [NumHosts];
  tlul_pkg::tl_d2h_t tl_h_rsp [NumHosts];
  tlul_pkg::tl_h2d_t tl_d_req;
  tlul_pkg::tl_d2h_t tl_d_rsp;

  // master: the hosts plus the shared device; slave: the arbiter itself
  modport master (
    output tl_h_req,
    input  tl_h_rsp,
    input  tl_d_req,
    output tl_d_rsp
  );

  modport slave (
    input  tl_h_req,
    output tl_h_rsp,
    output tl_d_req,
    input  tl_d_rsp
  );
endinterface

// File: rtl/scratchpad_port_arbiter.sv
// Shares one TL-UL device port among NumHosts hosts with in-order response routing.
// Define SCRATCHPAD_ARB_FIXED_PRIO_EN for fixed-priority (lowest index) arbitration.
module scratchpad_port_arbiter #(
  parameter int NumHosts       = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tlul_pkg::tl_h2d_t tl_h_i [NumHosts],
  output tlul_pkg::tl_d2h_t tl_h_o [NumHosts],
  output tlul_pkg::tl_h2d_t tl_d_o,
  input  tlul_pkg::tl_d2h_t tl_d_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {
    StArb,
    StLocked
  } state_e;

  state_e          state_q;
  logic [IdxW-1:0] lock_q;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            err_q;

  logic [IdxW-1:0] arb_idx;
  logic            arb_found;
  logic [IdxW-1:0] gnt;
  logic            gnt_valid;
  logic [IdxW-1:0] head;
  logic            full;
  logic            empty;
  logic            dev_a_valid;
  logic            dev_d_ready;
  logic            a_hs;
  logic            d_hs;
  logic            push;
  logic            pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full  = (count_q == CntW'(MaxOutstanding));
  assign empty = (count_q == '0);

`ifdef SCRATCHPAD_ARB_FIXED_PRIO_EN
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int i = NumHosts - 1; i >= 0; i--) begin
      if (tl_h_i[i].a_valid) begin
        arb_idx   = IdxW'(i);
        arb_found = 1'b1;
      end
    end
  end
`else
  logic [IdxW-1:0] last_q;

  // Scan from farthest to nearest so the host right after last_q wins.
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int off = NumHosts; off >= 1; off--) begin
      if (tl_h_i[(int'(last_q) + off) % NumHosts].a_valid) begin
        arb_idx   = IdxW'((int'(last_q) + off) % NumHosts);
        arb_found = 1'b1;
      end
    end
  end
`endif

  // Valid/ready: a beat transfers in the cycle valid and ready are both high;
  // a locked grant keeps the A payload stable until that cycle.
  assign gnt         = (state_q == StLocked) ? lock_q : arb_idx;
  assign gnt_valid   = tl_h_i[gnt].a_valid & ((state_q == StLocked) | arb_found);
  assign dev_a_valid = rst_ni & gnt_valid & ~full;
  assign a_hs        = dev_a_valid & tl_d_i.a_ready;

  assign head        = fifo_q[rd_ptr_q];
  assign dev_d_ready = rst_ni & (empty | tl_h_i[head].d_ready);
  assign d_hs        = tl_d_i.d_valid & dev_d_ready;
  assign push        = a_hs;
  assign pop         = d_hs & ~empty;

  always_comb begin
    tl_d_o         = tl_h_i[gnt];
    tl_d_o.a_valid = dev_a_valid;
    tl_d_o.d_ready = dev_d_ready;
  end

  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      tl_h_o[i]         = tl_d_i;
      tl_h_o[i].a_ready = rst_ni & tl_d_i.a_ready & (gnt == IdxW'(i)) & ~full;
      tl_h_o[i].d_valid = rst_ni & tl_d_i.d_valid & ~empty & (head == IdxW'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StArb;
      lock_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StArb: begin
          if (dev_a_valid && !tl_d_i.a_ready) begin
            state_q <= StLocked;
            lock_q  <= gnt;
          end
        end
        StLocked: begin
          if (a_hs) begin
            state_q <= StArb;
          end
        end
        default: state_q <= StArb;
      endcase

      if (push) begin
        fifo_q[wr_ptr_q] <= gnt;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase

      // A response with nothing outstanding is swallowed and flagged.
      if (tl_d_i.d_valid && empty) begin
        err_q <= 1'b1;
      end
    end
  end

`ifndef SCRATCHPAD_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= IdxW'(NumHosts - 1);
    end else if (push) begin
      last_q <= gnt;
    end
  end
`endif

  assign busy_o = (count_q != '0);
  assign err_o  = err_q;

endmodule

// File: tb/tb_scratchpad_port_arbiter.sv
// Directed bench for scratchpad_port_arbiter: contention, backpressure, full,
// response routing, spurious responses and reset mid-operation.
module tb_scratchpad_port_arbiter;
  import tlul_pkg::*;

  localparam int NH = 2;
  localparam int MO = 4;

  logic clk;
  logic rst_n;
  logic busy;
  logic err;

  int vectors     = 0;
  int miscompares = 0;

  logic [33:0] exp_q[$];
  logic [31:0] dev_q[$];

  scratchpad_port_arbiter_if #(.NumHosts(NH)) bus ();

  scratchpad_port_arbiter #(
    .NumHosts      (NH),
    .MaxOutstanding(MO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .tl_h_i(bus.tl_h_req),
    .tl_h_o(bus.tl_h_rsp),
    .tl_d_o(bus.tl_d_req),
    .tl_d_i(bus.tl_d_rsp),
    .busy_o(busy),
    .err_o (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // sram model: records accepted addresses in order
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.tl_d_req.a_valid === 1'b1 && bus.tl_d_rsp.a_ready === 1'b1)
      dev_q.push_back(bus.tl_d_req.a_address);
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  function automatic logic [1:0] ardy();
    return {bus.tl_h_rsp[1].a_ready, bus.tl_h_rsp[0].a_ready};
  endfunction

  function automatic logic [1:0] hdv();
    return {bus.tl_h_rsp[1].d_valid, bus.tl_h_rsp[0].d_valid};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic set_host(input int i, input logic v, input logic [31:0] a);
    bus.tl_h_req[i].a_valid   = v;
    bus.tl_h_req[i].a_opcode  = Get;
    bus.tl_h_req[i].a_size    = 2'd2;
    bus.tl_h_req[i].a_source  = 8'(i);
    bus.tl_h_req[i].a_address = a;
    bus.tl_h_req[i].a_mask    = 4'hf;
    bus.tl_h_req[i].d_ready   = 1'b1;
  endtask

  task automatic d_drive();
    logic [31:0] a;
    a = (dev_q.size() > 0) ? dev_q.pop_front() : 32'hdead_beef;
    bus.tl_d_rsp.d_valid  = 1'b1;
    bus.tl_d_rsp.d_opcode = AccessAckData;
    bus.tl_d_rsp.d_data   = mem_f(a);
  endtask

  task automatic d_check(input string tag);
    logic [33:0] e;
    int          hits;
    logic [1:0]  h;
    logic [31:0] dat;
    e    = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    hits = 0;
    h    = '1;
    dat  = '0;
    for (int i = 0; i < NH; i++) begin
      if (bus.tl_h_rsp[i].d_valid === 1'b1) begin
        hits++;
        h   = 2'(i);
        dat = bus.tl_h_rsp[i].d_data;
      end
    end
    chk({tag, "_hits"}, 64'(hits), 64'd1);
    chk({tag, "_route"}, 64'({h, dat}), 64'(e));
  endtask

  task automatic d_beat(input string tag);
    d_drive();
    @(negedge clk);
    d_check(tag);
    tick();
    bus.tl_d_rsp.d_valid = 1'b0;
  endtask

  initial begin
    int eh;
    logic [31:0] haddr [NH];
    haddr[0] = 32'h10;
    haddr[1] = 32'h20;

    bus.tl_d_rsp = '0;
    for (int i = 0; i < NH; i++) bus.tl_h_req[i] = '0;
    rst_n = 1'b0;

    // reset: outputs idle even with live inputs
    set_host(0, 1'b1, haddr[0]);
    set_host(1, 1'b0, haddr[1]);
    bus.tl_d_rsp.a_ready = 1'b1;
    bus.tl_d_rsp.d_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_a_ready", 64'(ardy()), 64'd0);
    chk("rst_d_valid", 64'(hdv()), 64'd0);
    chk("rst_dev_a_valid", 64'(bus.tl_d_req.a_valid), 64'd0);
    chk("rst_dev_d_ready", 64'(bus.tl_d_req.d_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    bus.tl_d_rsp.d_valid = 1'b0;
    set_host(0, 1'b0, haddr[0]);
    tick();
    rst_n = 1'b1;
    tick();

    // contention: both hosts valid, device always ready, until full
    set_host(0, 1'b1, haddr[0]);
    set_host(1, 1'b1, haddr[1]);
    for (int c = 0; c < MO; c++) begin
`ifdef SCRATCHPAD_ARB_FIXED_PRIO_EN
      eh = 0;
`else
      eh = c % 2;
`endif
      exp_q.push_back({2'(eh), mem_f(haddr[eh])});
      @(negedge clk);
      chk("cont_gnt", 64'(ardy()), 64'(2'b01 << eh));
      chk("cont_addr", 64'(bus.tl_d_req.a_address), 64'(haddr[eh]));
      tick();
    end

    // full: fifth request blocked
    @(negedge clk);
    chk("full_a_ready", 64'(ardy()), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    chk("full_dev_a_valid", 64'(bus.tl_d_req.a_valid), 64'd0);
    tick();

    // one pop while full: still blocked this cycle, granted the next
    d_drive();
    @(negedge clk);
    chk("full_pop_a_ready", 64'(ardy()), 64'd0);
    d_check("full_pop");
    tick();
    bus.tl_d_rsp.d_valid = 1'b0;
    exp_q.push_back({2'd0, mem_f(haddr[0])});
    @(negedge clk);
    chk("fifth_gnt", 64'(ardy()), 64'd1);
    tick();
    set_host(0, 1'b0, haddr[0]);
    set_host(1, 1'b0, haddr[1]);
    for (int k = 0; k < MO; k++) d_beat("drain");
    @(negedge clk);
    chk("drain_busy", 64'(busy), 64'd0);
    chk("drain_q_empty", 64'(exp_q.size()), 64'd0);
    tick();

    // backpressure: host 1 locked while device stalls 3 cycles
    bus.tl_d_rsp.a_ready = 1'b0;
    set_host(1, 1'b1, 32'h100);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_dev_a_valid", 64'(bus.tl_d_req.a_valid), 64'd1);
      chk("bp_addr", 64'(bus.tl_d_req.a_address), 64'h100);
      chk("bp_source", 64'(bus.tl_d_req.a_source), 64'd1);
      chk("bp_a_ready", 64'(ardy()), 64'd0);
      tick();
      set_host(0, 1'b1, haddr[0]);
    end
    bus.tl_d_rsp.a_ready = 1'b1;
    exp_q.push_back({2'd1, mem_f(32'h100)});
    @(negedge clk);
    chk("bp_accept", 64'(ardy()), 64'b10);
    chk("bp_accept_addr", 64'(bus.tl_d_req.a_address), 64'h100);
    tick();
    set_host(1, 1'b0, 32'h100);
    exp_q.push_back({2'd0, mem_f(haddr[0])});
    @(negedge clk);
    chk("bp_next_gnt", 64'(ardy()), 64'b01);
    chk("bp_next_addr", 64'(bus.tl_d_req.a_address), 64'(haddr[0]));
    tick();
    set_host(0, 1'b0, haddr[0]);
    d_beat("bp_d1");
    d_beat("bp_d2");

    // spurious response with nothing outstanding
    @(negedge clk);
    chk("spur_err_before", 64'(err), 64'd0);
    tick();
    bus.tl_d_rsp.d_valid = 1'b1;
    bus.tl_d_rsp.d_data  = 32'hbad0_0bad;
    @(negedge clk);
    chk("spur_d_ready", 64'(bus.tl_d_req.d_ready), 64'd1);
    chk("spur_d_valid", 64'(hdv()), 64'd0);
    tick();
    bus.tl_d_rsp.d_valid = 1'b0;
    @(negedge clk);
    chk("spur_err", 64'(err), 64'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("spur_err_held", 64'(err), 64'd1);
    chk("spur_busy", 64'(busy), 64'd0);
    tick();

    // reset with two requests outstanding
    set_host(0, 1'b1, haddr[0]);
    set_host(1, 1'b1, haddr[1]);
    repeat (2) tick();
    set_host(0, 1'b0, haddr[0]);
    set_host(1, 1'b0, haddr[1]);
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    tick();
    set_host(0, 1'b1, haddr[0]);
    set_host(1, 1'b1, haddr[1]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_a_ready", 64'(ardy()), 64'd0);
    chk("mid_rst_dev_a_valid", 64'(bus.tl_d_req.a_valid), 64'd0);
    dev_q.delete();
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    exp_q.push_back({2'd0, mem_f(haddr[0])});
    @(negedge clk);
    chk("post_rst_gnt", 64'(ardy()), 64'b01);
    tick();
    set_host(0, 1'b0, haddr[0]);
    set_host(1, 1'b0, haddr[1]);
    d_beat("post_rst_d");
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scratchpad_port_arbiter.md
SCRATCHPAD_PORT_ARBITER -- requirements
Module: scratchpad_port_arbiter

Interface
REQ-001 SHALL have parameter NumHosts, default 2, number of TL-UL host ports sharing one device port (range 2..4).
REQ-002 SHALL have parameter MaxOutstanding, default 4, maximum number of accepted A requests whose D responses are still pending (range 1..8).
REQ-003 SHALL have port clk_i, input, 1, system clock; all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port tl_h_i, input, NumHosts x tlul_pkg::tl_h2d_t, host requests.
REQ-006 SHALL have port tl_h_o, output, NumHosts x tlul_pkg::tl_d2h_t, host responses.
REQ-007 SHALL have port tl_d_o, output, tlul_pkg::tl_h2d_t, request toward the shared device (for example, an sram TL-UL port).
REQ-008 SHALL have port tl_d_i, input, tlul_pkg::tl_d2h_t, response from the shared device.
REQ-009 SHALL have port busy_o, output, 1, high while the outstanding count is nonzero.
REQ-010 SHALL have port err_o, output, 1, sticky flag for an unexpected D response.

Function
REQ-011 SHALL arbitrate among hosts whose a_valid is set, round-robin, giving highest priority to the host after the last granted host.
REQ-012 SHALL forward the granted host's A fields unmodified to tl_d_o; tl_d_o.a_valid = granted a_valid AND NOT full.
REQ-013 SHALL drive host a_ready = tl_d_i.a_ready AND (host == grant) AND NOT full; all other hosts SHALL see a_ready=0.
REQ-014 SHALL hold the grant (LOCKED state) while tl_d_o.a_valid=1 and tl_d_i.a_ready=0, so the A payload stays stable until acceptance.
REQ-015 SHALL implement a two-state FSM: ARB (grant recomputed each cycle) -> LOCKED on an unaccepted valid; LOCKED -> ARB on A handshake.
REQ-016 SHALL, on each A handshake, push the grant index into an in-order tracking FIFO of depth MaxOutstanding and update the round-robin pointer.
REQ-017 SHALL define full as count == MaxOutstanding; when full, it SHALL grant nothing and all a_ready SHALL be 0.
REQ-018 SHALL route tl_d_i D fields to the host at the FIFO head only; all other hosts SHALL see d_valid=0.
REQ-019 SHALL drive tl_d_o.d_ready = the head host's d_ready, and SHALL pop the FIFO on the D handshake.
REQ-020 SHALL, on a simultaneous push and pop, leave the count unchanged and wrap both FIFO pointers modulo MaxOutstanding.
REQ-021 SHALL, on tl_d_i.d_valid with an empty FIFO, drive d_ready=1, discard the beat and set err_o (sticky until reset).
REQ-022 SHALL pass a_ready/d_valid with zero added latency (combinational); a full round trip SHALL add no extra cycles.
REQ-023 SHALL allow a pop while full in the same cycle a new request is blocked; that request SHALL be granted the following cycle.

Reset
REQ-024 SHALL, on reset, clear the FIFO, count, FSM state (ARB), err_o and busy_o, and set the round-robin pointer so host 0 has highest priority.
REQ-025 SHALL drive all host a_ready/d_valid, tl_d_o.a_valid and tl_d_o.d_ready to 0 while rst_ni=0.
REQ-026 SHALL, on reset mid-transaction, discard pending responses; the system resets the device on the same reset.

Configuration
REQ-027 SHALL use macro SCRATCHPAD_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed-priority (the lowest host index wins) and the round-robin pointer is not implemented; when undefined, round-robin per REQ-011.

Verification
REQ-028 SHALL verify contention: hosts 0 and 1 both valid every cycle, device always ready -> grants alternate 0,1,0,1 (fixed-prio build: host 0 only).
REQ-029 SHALL verify backpressure: host 1 request addr 0x100, device a_ready=0 for 3 cycles, host 0 raises valid -> grant stays on host 1 until acceptance.
REQ-030 SHALL verify full: MaxOutstanding=4, 4 requests accepted, no D -> 5th a_ready=0, busy_o=1; one D pops -> 5th accepted next cycle.
REQ-031 SHALL verify routing: host 0 reads 0x10 then host 1 reads 0x20 -> first D reaches host 0 only, second reaches host 1 only, data matches the sram contents.
REQ-032 SHALL verify a spurious D: d_valid with an empty FIFO -> beat consumed, err_o=1 and held until rst_ni=0.
REQ-033 SHALL verify reset mid-op: 2 requests outstanding, assert rst_ni -> busy_o=0, err_o=0, outputs idle, first grant after release goes to host 0.
